// File: rtl/multi_item_vendor.sv
// Multi-item vending controller: coin credit, per-item prices and stock, greedy change.
// All outputs registered; pulses appear the cycle after the sampling edge; no backpressure, inputs are one-cycle pulses.
module multi_item_vendor #(
  parameter int NUM_ITEMS  = 4,
  parameter int CREDIT_W   = 8,
  parameter int CREDIT_MAX = 200,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd100, 8'd75, 8'd50, 8'd65},
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 10,
  parameter int SEL_W      = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                 ClkIn,
  input  logic                 Reset,
  input  logic                 N,
  input  logic                 D,
  input  logic                 Q,
  input  logic [SEL_W-1:0]     Sel,
  input  logic                 Vend,
  input  logic                 CoinReturn,
  input  logic                 Restock,
  output logic                 Dispense,
  output logic [SEL_W-1:0]     DispItem,
  output logic                 ChgN,
  output logic                 ChgD,
  output logic                 ChgQ,
  output logic                 CoinReject,
  output logic                 Denied,
  output logic [CREDIT_W-1:0]  Credit,
  output logic [NUM_ITEMS-1:0] SoldOut,
  output logic                 Busy
);

  typedef enum logic [1:0] {IDLE, HOLD, VEND, CHANGE} state_t;

  localparam logic [STOCK_W-1:0]  STOCK_INIT = STOCK_W'(INIT_STOCK);
  localparam logic [CREDIT_W:0]   MAX_SUM    = (CREDIT_W+1)'(CREDIT_MAX);

  state_t               state;
  logic [STOCK_W-1:0]   stock [NUM_ITEMS];

  logic [1:0]           coin_cnt;
  logic                 any_coin;
  logic                 one_coin;
  logic [CREDIT_W-1:0]  coin_val;
  logic [CREDIT_W:0]    coin_sum;
  logic                 coin_acc;
  logic [CREDIT_W-1:0]  cur_price;
  logic [STOCK_W-1:0]   cur_stock;
  logic                 sel_ok;
  logic                 vend_ok;
  logic                 chg_q;
  logic                 chg_d;
  logic                 chg_n;
  logic [CREDIT_W-1:0]  chg_val;
  logic                 do_chg;

  always_comb begin
    coin_cnt = 2'(N) + 2'(D) + 2'(Q);
    any_coin = N | D | Q;
    one_coin = (coin_cnt == 2'd1);
    coin_val = N ? CREDIT_W'(5) : (D ? CREDIT_W'(10) : CREDIT_W'(25));
    coin_sum = {1'b0, Credit} + {1'b0, coin_val};
    coin_acc = ((state == IDLE) || (state == HOLD)) && !Vend && !CoinReturn &&
               one_coin && (coin_sum <= MAX_SUM);

    // Sel values past NUM_ITEMS match nothing and leave sel_ok low.
    cur_price = '0;
    cur_stock = '0;
    sel_ok    = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (Sel == SEL_W'(i)) begin
        cur_price = PRICES[i*CREDIT_W +: CREDIT_W];
        cur_stock = stock[i];
        sel_ok    = 1'b1;
      end
    end
    vend_ok = sel_ok && (cur_stock != '0) && (Credit >= cur_price);

    chg_q   = (Credit >= CREDIT_W'(25));
    chg_d   = !chg_q && (Credit >= CREDIT_W'(10));
    chg_n   = !chg_q && !chg_d;
    chg_val = chg_q ? CREDIT_W'(25) : (chg_d ? CREDIT_W'(10) : CREDIT_W'(5));

    do_chg  = (state == CHANGE) ||
              ((state == VEND) && (Credit != '0)) ||
              ((state == HOLD) && !Vend && CoinReturn);
  end

  always_ff @(posedge ClkIn or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      Credit     <= '0;
      SoldOut    <= {NUM_ITEMS{STOCK_INIT == '0}};
      for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_INIT;
      Dispense   <= 1'b0;
      DispItem   <= '0;
      ChgN       <= 1'b0;
      ChgD       <= 1'b0;
      ChgQ       <= 1'b0;
      CoinReject <= 1'b0;
      Denied     <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      Dispense   <= 1'b0;
      DispItem   <= '0;
      ChgN       <= 1'b0;
      ChgD       <= 1'b0;
      ChgQ       <= 1'b0;
      Denied     <= 1'b0;
      Busy       <= 1'b0;
      CoinReject <= any_coin && !coin_acc;

      case (state)
        IDLE, HOLD: begin
          if (Vend) begin
            if (vend_ok) begin
              Dispense <= 1'b1;
              DispItem <= Sel;
              Credit   <= Credit - cur_price;
              Busy     <= 1'b1;
              state    <= VEND;
              for (int i = 0; i < NUM_ITEMS; i++) begin
                if (Sel == SEL_W'(i)) begin
                  stock[i]   <= stock[i] - STOCK_W'(1);
                  SoldOut[i] <= (stock[i] == STOCK_W'(1));
                end
              end
            end else begin
              Denied <= 1'b1;
            end
          end else begin
            if (Restock) begin
              for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_INIT;
              SoldOut <= {NUM_ITEMS{STOCK_INIT == '0}};
            end
            if (coin_acc) begin
              Credit <= coin_sum[CREDIT_W-1:0];
              state  <= HOLD;
            end
          end
        end
        VEND:    state <= IDLE;
        default: ;
      endcase

      // Change coins leave back-to-back; the last coin drops straight to IDLE so no dead cycle follows.
      if (do_chg) begin
        ChgQ   <= chg_q;
        ChgD   <= chg_d;
        ChgN   <= chg_n;
        Credit <= Credit - chg_val;
        Busy   <= 1'b1;
        state  <= (Credit == chg_val) ? IDLE : CHANGE;
      end
    end
  end

endmodule

// File: tb/tb_multi_item_vendor.sv
// Scoreboard bench for multi_item_vendor: transaction-level model predicts output events, a monitor checks them.
module tb_multi_item_vendor;
  localparam int NI = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          n_i = 1'b0, d_i = 1'b0, q_i = 1'b0;
  logic [SW-1:0] sel_i = '0;
  logic          vend_i = 1'b0, cret_i = 1'b0, rstk_i = 1'b0;
  logic          dispense, chg_n, chg_d, chg_q, coin_reject, denied, busy;
  logic [SW-1:0] disp_item;
  logic [7:0]    credit;
  logic [NI-1:0] sold_out;

  always #5 clk = ~clk;

  multi_item_vendor dut (
    .ClkIn(clk), .Reset(rst), .N(n_i), .D(d_i), .Q(q_i), .Sel(sel_i),
    .Vend(vend_i), .CoinReturn(cret_i), .Restock(rstk_i),
    .Dispense(dispense), .DispItem(disp_item), .ChgN(chg_n), .ChgD(chg_d), .ChgQ(chg_q),
    .CoinReject(coin_reject), .Denied(denied), .Credit(credit), .SoldOut(sold_out), .Busy(busy)
  );

  typedef struct packed {
    int cyc; bit disp; int item; bit cn; bit cd; bit cq; bit rej; bit den; bit busy; int credit; int so;
  } ev_t;

  int  price_tab [NI] = '{65, 50, 75, 100};
  int  errors = 0, checks = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;
  ev_t exp_q [$];

  // Reference model: credit, stock counts and a list of change coins still owed.
  int  m_credit;
  int  m_stock [NI];
  int  m_pend [$];
  bit  m_in_vend;
  int  p_credit, p_so;
  bit  p_busy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = 0;
    for (int i = 0; i < NI; i++) m_stock[i] = 10;
    m_pend.delete();
    m_in_vend = 1'b0;
    p_credit = 0; p_so = 0; p_busy = 1'b0;
  endtask

  task automatic owe_change(input int amount);
    int r;
    r = amount % 25;
    for (int k = 0; k < amount / 25; k++) m_pend.push_back(25);
    for (int k = 0; k < r / 10; k++) m_pend.push_back(10);
    for (int k = 0; k < (r % 10) / 5; k++) m_pend.push_back(5);
  endtask

  task automatic pay_coin(inout ev_t e);
    int c;
    c = m_pend.pop_front();
    if (c == 25) e.cq = 1'b1; else if (c == 10) e.cd = 1'b1; else e.cn = 1'b1;
    m_credit -= c;
  endtask

  task automatic model_step(input bit n, input bit d, input bit q, input int sel,
                            input bit vend, input bit cret, input bit rs);
    ev_t e;
    int  coins, val, so;
    e = '0;
    e.cyc = cyc + 1;
    coins = int'(n) + int'(d) + int'(q);
    if (m_in_vend || m_pend.size() > 0) begin
      m_in_vend = 1'b0;
      e.rej = (coins > 0);
      if (m_pend.size() > 0) pay_coin(e);
    end else if (vend) begin
      e.rej = (coins > 0);
      if (sel >= NI || m_stock[sel] == 0 || m_credit < price_tab[sel]) e.den = 1'b1;
      else begin
        e.disp = 1'b1; e.item = sel;
        m_credit -= price_tab[sel];
        m_stock[sel]--;
        m_in_vend = 1'b1;
        owe_change(m_credit);
      end
    end else begin
      if (rs) for (int i = 0; i < NI; i++) m_stock[i] = 10;
      if (cret) begin
        e.rej = (coins > 0);
        if (m_credit > 0) begin owe_change(m_credit); pay_coin(e); end
      end else if (coins > 0) begin
        val = n ? 5 : (d ? 10 : 25);
        if (coins == 1 && m_credit + val <= 200) m_credit += val;
        else e.rej = 1'b1;
      end
    end
    so = 0;
    for (int i = 0; i < NI; i++) if (m_stock[i] == 0) so |= (1 << i);
    e.busy = e.disp | e.cn | e.cd | e.cq;
    e.credit = m_credit;
    e.so = so;
    if (e.disp || e.cn || e.cd || e.cq || e.rej || e.den ||
        e.credit != p_credit || e.so != p_so || e.busy != p_busy)
      exp_q.push_back(e);
    p_credit = e.credit; p_so = e.so; p_busy = e.busy;
  endtask

  task automatic step(input bit n, input bit d, input bit q, input int sel,
                      input bit vend, input bit cret, input bit rs);
    @(negedge clk);
    n_i = n; d_i = d; q_i = q; sel_i = SW'(sel);
    vend_i = vend; cret_i = cret; rstk_i = rs;
    @(posedge clk);
    model_step(n, d, q, sel, vend, cret, rs);
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic coins_in(input int quarters, input int dimes, input int nickels);
    for (int k = 0; k < quarters; k++) step(0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < dimes; k++)    step(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < nickels; k++)  step(1, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: any pulse or any change of Credit/SoldOut/Busy is an event to match against the queue.
  int mp_credit, mp_so;
  bit mp_busy, mon_was;
  always @(negedge clk) begin
    ev_t a, x;
    if (!mon_en) mon_was = 1'b0;
    else begin
      if (!mon_was) begin mp_credit = 0; mp_so = 0; mp_busy = 1'b0; mon_was = 1'b1; end
      a = '0;
      a.cyc = cyc; a.disp = dispense; a.item = int'(disp_item);
      a.cn = chg_n; a.cd = chg_d; a.cq = chg_q; a.rej = coin_reject; a.den = denied;
      a.busy = busy; a.credit = int'(credit); a.so = int'(sold_out);
      if (a.disp || a.cn || a.cd || a.cq || a.rej || a.den ||
          a.credit != mp_credit || a.so != mp_so || a.busy != mp_busy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d disp=%0d item=%0d ndq=%0d%0d%0d rej=%0d den=%0d busy=%0d credit=%0d so=%0h",
                   a.cyc, a.disp, a.item, a.cn, a.cd, a.cq, a.rej, a.den, a.busy, a.credit, a.so);
        end else begin
          x = exp_q.pop_front();
          if (a != x) begin
            errors++;
            $display("FAIL event: got cyc=%0d disp=%0d item=%0d ndq=%0d%0d%0d rej=%0d den=%0d busy=%0d credit=%0d so=%0h; expected cyc=%0d disp=%0d item=%0d ndq=%0d%0d%0d rej=%0d den=%0d busy=%0d credit=%0d so=%0h",
                     a.cyc, a.disp, a.item, a.cn, a.cd, a.cq, a.rej, a.den, a.busy, a.credit, a.so,
                     x.cyc, x.disp, x.item, x.cn, x.cd, x.cq, x.rej, x.den, x.busy, x.credit, x.so);
          end
        end
      end
      mp_credit = a.credit; mp_so = a.so; mp_busy = a.busy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, sel, vend, cret, rs;
    bit n, d, q;

    #12;
    check("reset_credit", int'(credit), 0);
    check("reset_soldout", int'(sold_out), 0);
    check("reset_pulses", int'({dispense, chg_n, chg_d, chg_q, coin_reject, denied, busy}), 0);
    check("reset_dispitem", int'(disp_item), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;

    // Purchase with a dime of change.
    coins_in(3, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    #1;
    check("buy0_dispense", int'(dispense), 1);
    check("buy0_item", int'(disp_item), 0);
    check("buy0_credit", int'(credit), 10);
    step(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("buy0_chgd", int'(chg_d), 1);
    check("buy0_credit_after", int'(credit), 0);
    idle(1);
    #1;
    check("buy0_busy_low", int'(busy), 0);

    // Short credit, then refund.
    coins_in(2, 0, 0);
    step(0, 0, 0, 3, 1, 0, 0);
    #1;
    check("short_denied", int'(denied), 1);
    check("short_credit", int'(credit), 50);
    step(0, 0, 0, 0, 0, 1, 0);
    #1;
    check("refund_q1", int'(chg_q), 1);
    step(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("refund_q2", int'(chg_q), 1);
    check("refund_credit", int'(credit), 0);
    idle(2);

    // Credit ceiling and multi-coin rejection.
    coins_in(7, 1, 1);
    step(0, 0, 1, 0, 0, 0, 0);
    #1;
    check("ceiling_reject", int'(coin_reject), 1);
    check("ceiling_credit", int'(credit), 190);
    step(1, 1, 0, 0, 0, 0, 0);
    #1;
    check("double_coin_reject", int'(coin_reject), 1);
    coins_in(0, 1, 0);
    #1;
    check("ceiling_exact", int'(credit), 200);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(10);

    // Sell out item 1, deny, restock.
    for (int k = 0; k < 10; k++) begin
      coins_in(0, 5, 0);
      step(0, 0, 0, 1, 1, 0, 0);
      idle(1);
    end
    check("soldout1", int'(sold_out[1]), 1);
    coins_in(0, 5, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    #1;
    check("soldout_denied", int'(denied), 1);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(3);
    step(0, 0, 0, 0, 0, 0, 1);
    #1;
    check("restock_clears", int'(sold_out[1]), 0);

    // Vend with a coin in the same cycle, and a coin during change.
    coins_in(4, 0, 0);
    step(0, 0, 1, 1, 1, 0, 0);
    #1;
    check("vend_coin_dispense", int'(dispense), 1);
    check("vend_coin_reject", int'(coin_reject), 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    #1;
    check("change_coin_reject", int'(coin_reject), 1);
    check("change_credit", int'(credit), 0);
    idle(2);

    // Reset during the second refund coin.
    coins_in(3, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check("midreset_pulses", int'({dispense, chg_n, chg_d, chg_q, coin_reject, denied, busy}), 0);
    check("midreset_credit", int'(credit), 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      coins_in(0, 5, 0);
      step(0, 0, 0, 1, 1, 0, 0);
      idle(1);
    end
    check("post_reset_stock", int'(sold_out[1]), 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      n = 0; d = 0; q = 0;
      if (r < 35) begin
        case ($urandom_range(0, 2))
          0: n = 1;
          1: d = 1;
          default: q = 1;
        endcase
      end else if (r < 40) begin
        n = 1; q = 1; d = $urandom_range(0, 1);
      end
      sel  = $urandom_range(0, NI - 1);
      vend = ($urandom_range(0, 99) < 12) ? 1 : 0;
      cret = ($urandom_range(0, 99) < 3) ? 1 : 0;
      rs   = ($urandom_range(0, 99) < 2) ? 1 : 0;
      step(n, d, q, sel, vend[0], cret[0], rs[0]);
    end
    idle(20);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_item_vendor.md
# multi_item_vendor

Parametrised successor to the single-product vending FSM: accepts nickel/dime/quarter pulses, holds credit, sells one of NUM_ITEMS products at per-item prices, tracks per-item stock, and returns change as a sequence of coin pulses. It sits between the button synchronizers (coin/select/vend inputs, one-cycle pulses on the divided clock) and the two-digit display (Credit output).

## Interface
- NUM_ITEMS, 4, number of products (1..16)
- CREDIT_W, 8, width of credit and prices, in cents
- CREDIT_MAX, 200, credit ceiling in cents; must be a multiple of 5 and ≤ 2^CREDIT_W−1
- PRICES, {8'd100,8'd75,8'd50,8'd65}, flattened NUM_ITEMS×CREDIT_W vector; item i at bits [i*CREDIT_W +: CREDIT_W]; every price a nonzero multiple of 5
- STOCK_W, 4, per-item stock counter width
- INIT_STOCK, 10, stock loaded at reset and on Restock
- ClkIn  in  1  clock; the only clock
- Reset  in  1  asynchronous, active-high
- N, D, Q  in  1 each  coin pulses worth 5/10/25 cents
- Sel  in  $clog2(NUM_ITEMS) (min 1)  item index, sampled with Vend
- Vend  in  1  purchase request pulse
- CoinReturn  in  1  refund request pulse
- Restock  in  1  reload all stock to INIT_STOCK
- Dispense  out  1  one-cycle product release pulse
- DispItem  out  Sel width  item released; valid with Dispense, else 0
- ChgN, ChgD, ChgQ  out  1 each  one-cycle change coin pulses
- CoinReject  out  1  one-cycle pulse: offered coin(s) not accepted, returned
- Denied  out  1  one-cycle pulse: Vend refused (sold out, bad Sel, or short credit)
- Credit  out  CREDIT_W  current credit in cents
- SoldOut  out  NUM_ITEMS  bit i = stock of item i is zero
- Busy  out  1  high in VEND and CHANGE

## Operation
- States: IDLE (credit 0), HOLD (credit > 0), VEND, CHANGE.
- Reset: state IDLE, Credit 0, all stock INIT_STOCK, SoldOut 0 (unless INIT_STOCK = 0), all pulse outputs 0, DispItem 0, Busy 0.
- Priority among inputs sampled in IDLE/HOLD in one cycle: Vend > CoinReturn > coin. A coin arriving alongside an accepted or denied Vend, or alongside CoinReturn, is rejected.
- Coin: exactly one of N/D/Q high -> accepted if Credit + value ≤ CREDIT_MAX (sum computed at CREDIT_W+1 bits), Credit updated next cycle, IDLE→HOLD. Over-ceiling or two or more coins high in the same cycle -> CoinReject, Credit unchanged.
- Vend: Denied if Sel ≥ NUM_ITEMS, stock[Sel] = 0, or Credit < price[Sel]; state and Credit unchanged. Otherwise go to VEND.
- VEND (one cycle): Dispense = 1, DispItem = Sel latched at request, Credit −= price, stock[Sel] −= 1. Next state CHANGE if remainder > 0, else IDLE.
- CoinReturn in HOLD -> CHANGE. Ignored in IDLE.
- CHANGE: one coin per cycle, greedy: ChgQ if Credit ≥ 25, else ChgD if ≥ 10, else ChgN. Credit decremented in the same edge. Go to IDLE when Credit reaches 0.
- In VEND/CHANGE: any coin -> CoinReject; Vend, CoinReturn and Restock are ignored, with no Denied.
- Restock is honoured only in IDLE/HOLD and only when no Vend is in the same cycle. It sets every stock to INIT_STOCK, and SoldOut updates next cycle.
- Stock never decrements below 0. The sold-out check guarantees this.

## Timing
- All outputs are registered. Every pulse output rises one cycle after the sampled input edge and lasts exactly one cycle.
- Purchase latency: Vend sampled at edge k -> Dispense high in cycle k+1 -> first change coin in cycle k+2.
- Change duration equals the greedy coin count for the remaining credit, with no gap cycles. Busy stays high from VEND through the last change pulse.
- A pulse held for more than one cycle counts as one event per cycle. The upstream synchronizers guarantee single-cycle pulses.
- Asynchronous Reset at any time, including mid-CHANGE, forces the reset values immediately. Undispensed change is forfeited.

## Test plan
- Reset, then Q,Q,Q (75), Vend Sel=0 (65) -> Dispense with DispItem=0 one cycle after Vend, Credit=10, then one ChgD cycle, Credit=0, IDLE, stock0=9.
- Credit 50, Vend Sel=3 (100) -> Denied, Credit stays 50. CoinReturn -> ChgQ, ChgQ on consecutive cycles, then Credit=0.
- Credit 190, Q -> CoinReject, Credit 190. Then N,D in the same cycle -> CoinReject. Then D -> Credit 200.
- Buy item 1 ten times with D×5 each -> SoldOut[1]=1 after the 10th. 11th Vend -> Denied. Restock in IDLE -> SoldOut[1]=0 the next cycle.
- Credit 100, Vend Sel=1 with Q in the same cycle -> Dispense plus CoinReject. Change of 50 gives ChgQ, ChgQ. Q sent during CHANGE -> CoinReject, with no credit change.
- Credit 85, CoinReturn, Reset asserted during the second change pulse -> all outputs zero at once, Credit 0, stock back to INIT_STOCK.
